// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports, optional
// write-to-read bypass, optional hard-wired zero entry and a sequenced bulk-clear sweep.
module regfile_param #(
  parameter int WIDTH   = 10,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic             CLKb,
  input  logic             RSTb,
  input  logic [WIDTH-1:0] D,
  input  logic             ENW,
  input  logic [AW-1:0]    WRA,
  input  logic             ENR0,
  input  logic [AW-1:0]    RDA0,
  input  logic             ENR1,
  input  logic [AW-1:0]    RDA1,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic             BUSY
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] q0_q, q0_d;
  logic [WIDTH-1:0] q1_q, q1_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             wr_en_s;
  logic             byp0_s, byp1_s;
  logic [WIDTH-1:0] rd0_raw_s, rd1_raw_s;

  // An address is usable if it lies inside the array and is not the hard-wired zero entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = ({1'b0, a} < DEPTH_W) && !((ZERO_R0 != 0) && (a == {AW{1'b0}}));
  endfunction

  // Raw array reads; illegal addresses read as zero.
  always_comb begin
    rd0_raw_s = {WIDTH{1'b0}};
    rd1_raw_s = {WIDTH{1'b0}};
    if (addr_ok(RDA0)) begin
      rd0_raw_s = mem_q[RDA0];
    end else begin
      rd0_raw_s = {WIDTH{1'b0}};
    end
    if (addr_ok(RDA1)) begin
      rd1_raw_s = mem_q[RDA1];
    end else begin
      rd1_raw_s = {WIDTH{1'b0}};
    end
  end

  // Next-state logic: write/read in IDLE, one entry cleared per edge in SWEEP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    q0_d    = {WIDTH{1'b0}};
    q1_d    = {WIDTH{1'b0}};
    wr_en_s = 1'b0;
    byp0_s  = 1'b0;
    byp1_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // CLR wins over a write on the same edge.
        if (CLR) begin
          state_d = ST_SWEEP;
          busy_d  = 1'b1;
          ptr_d   = {AW{1'b0}};
          wr_en_s = 1'b0;
        end else begin
          wr_en_s = ENW && addr_ok(WRA);
        end
        byp0_s = (BYPASS != 0) && wr_en_s && (WRA == RDA0);
        byp1_s = (BYPASS != 0) && wr_en_s && (WRA == RDA1);
        for (int i = 0; i < DEPTH; i++) begin
          mem_d[i] = (wr_en_s && (WRA == AW'(i))) ? D : mem_q[i];
        end
        q0_d = !ENR0 ? {WIDTH{1'b0}} : (byp0_s ? D : rd0_raw_s);
        q1_d = !ENR1 ? {WIDTH{1'b0}} : (byp1_s ? D : rd1_raw_s);
      end
      ST_SWEEP: begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_d[i] = (ptr_q == AW'(i)) ? {WIDTH{1'b0}} : mem_q[i];
        end
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          ptr_d   = {AW{1'b0}};
        end else begin
          ptr_d   = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ptr_d   = {AW{1'b0}};
      end
    endcase
  end

  // State, array and output registers; all updates on the falling clock edge.
  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= ST_IDLE;
      ptr_q   <= {AW{1'b0}};
      busy_q  <= 1'b0;
      q0_q    <= {WIDTH{1'b0}};
      q1_q    <= {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign Q0   = q0_q;
  assign Q1   = q1_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: three instances (bypass, no bypass, DEPTH=6 with
// zero entry) share one stimulus stream; each check targets the relevant instance.
module tb_regfile_param;

  logic       CLKb;
  logic       RSTb;
  logic [9:0] D;
  logic       ENW;
  logic [2:0] WRA;
  logic       ENR0;
  logic [2:0] RDA0;
  logic       ENR1;
  logic [2:0] RDA1;
  logic       CLR;

  logic [9:0] q0_b, q1_b, q0_n, q1_n, q0_z, q1_z;
  logic       busy_b, busy_n, busy_z;

  int tests_run    = 0;
  int tests_failed = 0;

  regfile_param #(.WIDTH(10), .DEPTH(8), .BYPASS(1), .ZERO_R0(0)) u_byp (
    .CLKb(CLKb), .RSTb(RSTb), .D(D), .ENW(ENW), .WRA(WRA),
    .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1), .CLR(CLR),
    .Q0(q0_b), .Q1(q1_b), .BUSY(busy_b)
  );

  regfile_param #(.WIDTH(10), .DEPTH(8), .BYPASS(0), .ZERO_R0(0)) u_nobyp (
    .CLKb(CLKb), .RSTb(RSTb), .D(D), .ENW(ENW), .WRA(WRA),
    .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1), .CLR(CLR),
    .Q0(q0_n), .Q1(q1_n), .BUSY(busy_n)
  );

  regfile_param #(.WIDTH(10), .DEPTH(6), .BYPASS(1), .ZERO_R0(1)) u_zero (
    .CLKb(CLKb), .RSTb(RSTb), .D(D), .ENW(ENW), .WRA(WRA),
    .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1), .CLR(CLR),
    .Q0(q0_z), .Q1(q1_z), .BUSY(busy_z)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge CLKb);
    @(posedge CLKb);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  int cnt_b;
  int cnt_z;

  initial begin
    RSTb = 1'b0; D = 10'h000; ENW = 1'b0; WRA = 3'd0;
    ENR0 = 1'b0; RDA0 = 3'd0; ENR1 = 1'b0; RDA1 = 3'd0; CLR = 1'b0;
    tick(); tick();
    chk("rst_q0", 16'(q0_b), 16'h0000);
    chk("rst_q1", 16'(q1_b), 16'h0000);
    chk("rst_busy", 16'(busy_b), 16'h0000);
    RSTb = 1'b1;

    // 1. reset between edges
    ENW = 1'b1; WRA = 3'd3; D = 10'h155; tick();
    ENW = 1'b0; ENR0 = 1'b1; RDA0 = 3'd3; ENR1 = 1'b1; RDA1 = 3'd3; tick();
    chk("pre_rst_q0", 16'(q0_b), 16'h0155);
    RSTb = 1'b0; #1;
    chk("async_rst_q0", 16'(q0_b), 16'h0000);
    chk("async_rst_q1", 16'(q1_b), 16'h0000);
    chk("async_rst_busy", 16'(busy_b), 16'h0000);
    #1; RSTb = 1'b1;
    tick();
    chk("post_rst_entry3", 16'(q0_b), 16'h0000);

    // 2. basic write/read
    ENR0 = 1'b0; ENR1 = 1'b0;
    ENW = 1'b1; WRA = 3'd5; D = 10'h2A5; tick();
    WRA = 3'd6; D = 10'h00F; tick();
    ENW = 1'b0; ENR0 = 1'b1; RDA0 = 3'd5; ENR1 = 1'b1; RDA1 = 3'd6; tick();
    chk("rd_q0", 16'(q0_b), 16'h02A5);
    chk("rd_q1", 16'(q1_b), 16'h000F);
    chk("rd_nobyp_q0", 16'(q0_n), 16'h02A5);
    chk("rd_z_q0", 16'(q0_z), 16'h02A5);
    chk("rd_z_oob_q1", 16'(q1_z), 16'h0000);
    ENR0 = 1'b0; tick();
    chk("en0_off_q0", 16'(q0_b), 16'h0000);
    chk("en0_off_q1", 16'(q1_b), 16'h000F);

    // 3. bypass
    ENR1 = 1'b0;
    ENW = 1'b1; WRA = 3'd2; D = 10'h001; tick();
    ENR0 = 1'b1; RDA0 = 3'd2; D = 10'h3FF; tick();
    chk("byp_q0", 16'(q0_b), 16'h03FF);
    chk("nobyp_old_q0", 16'(q0_n), 16'h0001);
    ENW = 1'b0; tick();
    chk("nobyp_new_q0", 16'(q0_n), 16'h03FF);

    // 4. clear sweep
    ENR0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ENW = 1'b1; WRA = 3'(i); D = 10'(10'h040 + i); tick();
    end
    ENW = 1'b0; ENR0 = 1'b1; RDA0 = 3'd7; tick();
    chk("fill_q0", 16'(q0_b), 16'h0047);
    ENW = 1'b1; WRA = 3'd1; D = 10'h123; CLR = 1'b1; tick();
    cnt_b = busy_b ? 1 : 0;
    cnt_z = busy_z ? 1 : 0;
    for (int j = 1; j <= 8; j++) begin
      ENW = 1'b1; WRA = 3'(j % 8); D = 10'h3FF; CLR = (j == 3);
      ENR0 = 1'b1; RDA0 = 3'(j % 8); ENR1 = 1'b1; RDA1 = 3'd7;
      tick();
      if (busy_b) cnt_b++;
      if (busy_z) cnt_z++;
      if (j == 4) chk("sweep_q0_gated", 16'(q0_b), 16'h0000);
    end
    ENW = 1'b0; CLR = 1'b0; ENR0 = 1'b0; ENR1 = 1'b0; tick();
    if (busy_b) cnt_b++;
    if (busy_z) cnt_z++;
    chk("busy_cycles_d8", 16'(cnt_b), 16'd8);
    chk("busy_cycles_d6", 16'(cnt_z), 16'd6);
    for (int i = 0; i < 8; i++) begin
      ENR0 = 1'b1; RDA0 = 3'(i); tick();
      chk($sformatf("cleared_%0d", i), 16'(q0_b), 16'h0000);
    end

    // 5. reset mid-sweep
    ENW = 1'b1; WRA = 3'd7; D = 10'h0AA; tick();
    ENW = 1'b0; CLR = 1'b1; tick();
    CLR = 1'b0; tick(); tick();
    chk("midsweep_busy", 16'(busy_b), 16'h0001);
    RSTb = 1'b0; #1;
    chk("midsweep_rst_busy", 16'(busy_b), 16'h0000);
    #1; RSTb = 1'b1;
    ENW = 1'b1; WRA = 3'd4; D = 10'h0AA; tick();
    ENW = 1'b0; ENR0 = 1'b1; RDA0 = 3'd4; tick();
    chk("idle_after_rst", 16'(q0_b), 16'h00AA);
    ENW = 1'b1; WRA = 3'd0; D = 10'h0BB; tick();
    ENW = 1'b0; CLR = 1'b1; tick();
    CLR = 1'b0; cnt_b = 0;
    for (int j = 0; j < 12; j++) begin
      if (busy_b) cnt_b++;
      tick();
    end
    chk("restart_busy_cycles", 16'(cnt_b), 16'd8);
    RDA0 = 3'd0; RDA1 = 3'd4; ENR1 = 1'b1; tick();
    chk("restart_entry0", 16'(q0_b), 16'h0000);
    chk("restart_entry4", 16'(q1_b), 16'h0000);

    // 6. DEPTH=6, ZERO_R0=1 boundaries
    ENR0 = 1'b0; ENR1 = 1'b0;
    ENW = 1'b1; WRA = 3'd7; D = 10'h3FF; tick();
    WRA = 3'd0; tick();
    WRA = 3'd5; D = 10'h011; tick();
    ENW = 1'b0; ENR0 = 1'b1; RDA0 = 3'd0; ENR1 = 1'b1; RDA1 = 3'd7; tick();
    chk("z_rd0", 16'(q0_z), 16'h0000);
    chk("z_rd7", 16'(q1_z), 16'h0000);
    chk("b_rd0", 16'(q0_b), 16'h03FF);
    chk("b_rd7", 16'(q1_b), 16'h03FF);
    RDA0 = 3'd5; ENR1 = 1'b0; tick();
    chk("z_rd5", 16'(q0_z), 16'h0011);
    for (int i = 1; i < 5; i++) begin
      RDA0 = 3'(i); tick();
      chk($sformatf("z_unchanged_%0d", i), 16'(q0_z), 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
